// File: rtl/hangman_engine.sv
// Hangman game core: secret word fetched from an external ROM at an LFSR-chosen index,
// guesses taken over valid/ready and scanned one letter position per cycle.
module hangman_engine #(
  parameter int unsigned WORD_LEN  = 5,
  parameter int unsigned LETTER_W  = 5,
  parameter int unsigned MAX_TRIES = 7,
  parameter int unsigned LFSR_W    = 6,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'b110000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         guess_valid,
  input  logic [LETTER_W-1:0]          guess_letter,
  output logic                         guess_ready,
  output logic [LFSR_W-1:0]            word_index,
  input  logic [WORD_LEN*LETTER_W-1:0] word_data,
  output logic [WORD_LEN-1:0]          revealed,
  output logic [3:0]                   tries_used,
  output logic                         guess_hit,
  output logic                         guess_miss,
  output logic                         guess_dup,
  output logic                         win,
  output logic                         lose,
  output logic                         busy
);

  localparam int unsigned NUM_LETTERS = 1 << LETTER_W;
  localparam int unsigned POS_W       = $clog2(WORD_LEN);
  localparam logic [3:0]  MAX_T       = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GUESS,
    S_SCAN,
    S_UPDATE,
    S_WIN,
    S_LOSE
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [LFSR_W-1:0]            lfsr;
  logic [WORD_LEN*LETTER_W-1:0] word_q;
  logic [NUM_LETTERS-1:0]       used;
  logic [LETTER_W-1:0]          letter;
  logic [POS_W-1:0]             pos;
  logic                         hit;
  logic [WORD_LEN-1:0]          hit_mask;
  logic                         last_pos;

  assign last_pos = (pos == POS_W'(WORD_LEN - 1));

  // Outputs decoded purely from registered state
  assign guess_ready = (state == S_GUESS);
  assign busy        = (state == S_LOAD) || (state == S_SCAN) || (state == S_UPDATE);
  assign win         = (state == S_WIN);
  assign lose        = (state == S_LOSE);
  assign guess_hit   = (state == S_UPDATE) && hit;
  assign guess_miss  = (state == S_UPDATE) && !hit;

  // One-hot match of the latched letter at the current scan position
  always_comb begin
    hit_mask = '0;
    for (int p = 0; p < WORD_LEN; p++) begin
      hit_mask[p] = (pos == POS_W'(p)) && (word_q[p*LETTER_W +: LETTER_W] == letter);
    end
  end

  // Word-index LFSR runs freely; abort leaves it alone so games stay varied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_WIN, S_LOSE: state_next = start ? S_LOAD : state;
        S_LOAD:                state_next = S_GUESS;
        S_GUESS:               state_next = (guess_valid && !used[guess_letter]) ? S_SCAN : S_GUESS;
        S_SCAN:                state_next = last_pos ? S_UPDATE : S_SCAN;
        S_UPDATE: begin
          if (hit) begin
            state_next = (&revealed) ? S_WIN : S_GUESS;
          end else begin
            state_next = ((tries_used + 4'd1) == MAX_T) ? S_LOSE : S_GUESS;
          end
        end
        default:               state_next = S_IDLE;
      endcase
    end
  end

  // Game datapath: word latch, letter bitmap, scan pointer, reveal mask, try count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_index <= '0;
      word_q     <= '0;
      used       <= '0;
      letter     <= '0;
      pos        <= '0;
      hit        <= 1'b0;
      revealed   <= '0;
      tries_used <= 4'd0;
      guess_dup  <= 1'b0;
    end else if (abort) begin
      used       <= '0;
      hit        <= 1'b0;
      revealed   <= '0;
      tries_used <= 4'd0;
      guess_dup  <= 1'b0;
    end else begin
      guess_dup <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            word_index <= lfsr;
            used       <= '0;
            revealed   <= '0;
            tries_used <= 4'd0;
          end
        end
        S_LOAD: word_q <= word_data;
        S_GUESS: begin
          if (guess_valid) begin
            if (used[guess_letter]) begin
              guess_dup <= 1'b1;
            end else begin
              used[guess_letter] <= 1'b1;
              letter             <= guess_letter;
              pos                <= '0;
              hit                <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          revealed <= revealed | hit_mask;
          if (|hit_mask) begin
            hit <= 1'b1;
          end
          pos <= pos + POS_W'(1);
        end
        S_UPDATE: begin
          if (!hit && (tries_used < MAX_T)) begin
            tries_used <= tries_used + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hangman_engine.sv
// Directed bench for hangman_engine: default 5-letter build plus an 8-letter, 3-try build.
module tb_hangman_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [24:0] WORD5 = {5'd14, 5'd11, 5'd11, 5'd4, 5'd7};
  localparam logic [39:0] WORD8 = {5'd2, 5'd1, 5'd0, 5'd14, 5'd11, 5'd11, 5'd4, 5'd7};

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       guess_valid = 1'b0;
  logic [4:0] guess_letter = 5'd0;
  logic       sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [5:0] wi5, wi8;
  logic [4:0] rev5;
  logic [7:0] rev8;
  logic [3:0] tr5, tr8;
  logic hit5, miss5, dup5, win5, lose5, busy5, rdy5;
  logic hit8, miss8, dup8, win8, lose8, busy8, rdy8;

  hangman_engine dut5 (
    .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
    .guess_valid(guess_valid & ~sel), .guess_letter(guess_letter), .guess_ready(rdy5),
    .word_index(wi5), .word_data(WORD5), .revealed(rev5), .tries_used(tr5),
    .guess_hit(hit5), .guess_miss(miss5), .guess_dup(dup5), .win(win5), .lose(lose5), .busy(busy5)
  );

  hangman_engine #(.WORD_LEN(8), .MAX_TRIES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
    .guess_valid(guess_valid & sel), .guess_letter(guess_letter), .guess_ready(rdy8),
    .word_index(wi8), .word_data(WORD8), .revealed(rev8), .tries_used(tr8),
    .guess_hit(hit8), .guess_miss(miss8), .guess_dup(dup8), .win(win8), .lose(lose8), .busy(busy8)
  );

  logic [5:0] o_wi;
  logic [7:0] o_rev;
  logic [3:0] o_tr;
  logic o_hit, o_miss, o_dup, o_win, o_lose, o_busy, o_rdy;
  assign o_wi   = sel ? wi8 : wi5;
  assign o_rev  = sel ? rev8 : {3'b000, rev5};
  assign o_tr   = sel ? tr8 : tr5;
  assign o_hit  = sel ? hit8 : hit5;
  assign o_miss = sel ? miss8 : miss5;
  assign o_dup  = sel ? dup8 : dup5;
  assign o_win  = sel ? win8 : win5;
  assign o_lose = sel ? lose8 : lose5;
  assign o_busy = sel ? busy8 : busy5;
  assign o_rdy  = sel ? rdy8 : rdy5;

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    guess_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Offers one guess from GUESS; returns cycles from acceptance to the first result pulse
  task automatic do_guess(input logic [4:0] l, output int lat);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL guess_ready_before_guess: got %b want 1", o_rdy);
    end
    guess_letter = l;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    lat = 1;
    while (!(o_hit || o_miss || o_dup) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_wi, o_rev, o_tr} !== 18'd0) begin
      errors++;
      $display("FAIL reset_values: got wi=%0d rev=%b tries=%0d want 0/0/0", o_wi, o_rev, o_tr);
    end
    checks++;
    if ({o_hit, o_miss, o_dup, o_win, o_lose, o_busy, o_rdy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000", {o_hit, o_miss, o_dup, o_win, o_lose, o_busy, o_rdy});
    end
  endtask

  task automatic test_lfsr();
    logic [5:0] exp_seq [6];
    exp_seq = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd33};
    sel = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      repeat (k) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_wi !== exp_seq[k]) begin
        errors++;
        $display("FAIL lfsr_index_%0d: got %0d want %0d", k, o_wi, exp_seq[k]);
      end
    end
  endtask

  task automatic test_start();
    sel = 1'b0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({o_busy, o_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL start_load: got busy,ready=%b want 10", {o_busy, o_rdy});
    end
    @(negedge clk);
    checks++;
    if ({o_busy, o_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL start_guess: got busy,ready=%b want 01", {o_busy, o_rdy});
    end
  endtask

  task automatic test_hit(input logic s);
    int lat;
    int wl;
    sel = s;
    wl = s ? 8 : 5;
    do_reset();
    start_game();
    do_guess(5'd11, lat);
    checks++;
    if (lat != wl + 1 || o_hit !== 1'b1 || o_miss !== 1'b0) begin
      errors++;
      $display("FAIL hit_latency_w%0d: got lat=%0d hit=%b miss=%b want %0d/1/0", wl, lat, o_hit, o_miss, wl + 1);
    end
    checks++;
    if (o_rev !== 8'b0000_1100 || o_tr !== 4'd0) begin
      errors++;
      $display("FAIL hit_revealed_w%0d: got rev=%b tries=%0d want 00001100/0", wl, o_rev, o_tr);
    end
    @(negedge clk);
    checks++;
    if ({o_rdy, o_hit} !== 2'b10) begin
      errors++;
      $display("FAIL hit_back_to_guess_w%0d: got ready,hit=%b want 10", wl, {o_rdy, o_hit});
    end
  endtask

  task automatic test_win();
    int lat;
    logic [4:0] ls [4];
    logic bad;
    ls = '{5'd7, 5'd4, 5'd11, 5'd14};
    sel = 1'b0;
    bad = 1'b0;
    do_reset();
    start_game();
    for (int i = 0; i < 4; i++) begin
      do_guess(ls[i], lat);
      if (lat != 6 || o_hit !== 1'b1) bad = 1'b1;
      if (i < 3) @(negedge clk);
    end
    checks++;
    if (bad || o_rev !== 8'b0001_1111) begin
      errors++;
      $display("FAIL win_guesses: got bad=%b rev=%b want 0/00011111", bad, o_rev);
    end
    @(negedge clk);
    checks++;
    if ({o_win, o_rdy, o_busy} !== 3'b100) begin
      errors++;
      $display("FAIL win_state: got win,ready,busy=%b want 100", {o_win, o_rdy, o_busy});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({o_busy, o_win} !== 2'b10 || o_rev !== 8'd0) begin
      errors++;
      $display("FAIL win_restart: got busy,win=%b rev=%b want 10/0", {o_busy, o_win}, o_rev);
    end
  endtask

  task automatic test_lose(input logic s);
    int lat;
    int mt;
    logic [4:0] ls [7];
    logic bad;
    ls = '{5'd3, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd12};
    sel = s;
    mt = s ? 3 : 7;
    do_reset();
    start_game();
    for (int i = 0; i < mt; i++) begin
      do_guess(ls[i], lat);
      checks++;
      if (lat != (s ? 9 : 6) || o_miss !== 1'b1 || o_hit !== 1'b0) begin
        errors++;
        $display("FAIL miss_pulse_%0d: got lat=%0d miss=%b hit=%b want %0d/1/0", i, lat, o_miss, o_hit, s ? 9 : 6);
      end
      @(negedge clk);
      checks++;
      if (o_tr !== 4'(i + 1) || o_lose !== (i + 1 == mt)) begin
        errors++;
        $display("FAIL tries_%0d: got tries=%0d lose=%b want %0d/%b", i, o_tr, o_lose, i + 1, i + 1 == mt);
      end
    end
    bad = 1'b0;
    guess_letter = 5'd13;
    guess_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_hit || o_miss || o_dup || o_rdy) bad = 1'b1;
    end
    guess_valid = 1'b0;
    checks++;
    if (bad || o_tr !== 4'(mt) || o_lose !== 1'b1) begin
      errors++;
      $display("FAIL lose_ignores_guess: got bad=%b tries=%0d lose=%b want 0/%0d/1", bad, o_tr, o_lose, mt);
    end
  endtask

  task automatic test_dup();
    int lat;
    sel = 1'b0;
    do_reset();
    start_game();
    do_guess(5'd11, lat);
    @(negedge clk);
    do_guess(5'd11, lat);
    checks++;
    if (lat != 1 || o_dup !== 1'b1 || o_rdy !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL dup_pulse: got lat=%0d dup=%b ready=%b busy=%b want 1/1/1/0", lat, o_dup, o_rdy, o_busy);
    end
    checks++;
    if (o_tr !== 4'd0 || o_rev !== 8'b0000_1100) begin
      errors++;
      $display("FAIL dup_no_change: got tries=%0d rev=%b want 0/00001100", o_tr, o_rev);
    end
    do_guess(5'd7, lat);
    checks++;
    if (lat != 6 || o_hit !== 1'b1 || o_rev !== 8'b0000_1101) begin
      errors++;
      $display("FAIL after_dup_guess: got lat=%0d hit=%b rev=%b want 6/1/00001101", lat, o_hit, o_rev);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic bad;
    sel = 1'b0;
    do_reset();
    start_game();
    guess_letter = 5'd11;
    guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_rev !== 8'b0000_0100 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL scan_partial: got rev=%b busy=%b want 00000100/1", o_rev, o_busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (o_rev !== 8'd0 || {o_busy, o_rdy, o_tr} !== 6'd0) begin
      errors++;
      $display("FAIL abort_idle: got rev=%b busy,ready,tries=%b want 0/0", o_rev, {o_busy, o_rdy, o_tr});
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_hit || o_miss || o_dup || o_busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_pulse: got activity=%b want 0", bad);
    end
    start_game();
    do_guess(5'd11, lat);
    checks++;
    if (o_hit !== 1'b1 || o_dup !== 1'b0) begin
      errors++;
      $display("FAIL abort_clears_used: got hit=%b dup=%b want 1/0", o_hit, o_dup);
    end
  endtask

  task automatic test_reset_update();
    int lat;
    logic bad;
    sel = 1'b0;
    do_reset();
    start_game();
    do_guess(5'd11, lat);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({o_hit, o_busy, o_rdy} !== 3'b000 || o_rev !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got hit,busy,ready=%b rev=%b want 000/0", {o_hit, o_busy, o_rdy}, o_rev);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_hit || o_miss || o_busy || o_rev != 8'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_stays_idle: got activity=%b want 0", bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_lfsr();
    test_start();
    test_hit(1'b0);
    test_win();
    test_lose(1'b0);
    test_dup();
    test_abort();
    test_reset_update();
    test_hit(1'b1);
    test_lose(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
